// File: rtl/wb_burst_master_if.sv
// Signal bundle between wb_burst_master and its command/data streams and Wishbone slave.
// The master modport is the burst engine; the slave modport is everything around it.
interface wb_burst_master_if #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int LENW = 8
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [LENW-1:0] cmd_len;

  logic            wr_valid;
  logic            wr_ready;
  logic [DW-1:0]   wr_data;

  logic            rd_valid;
  logic            rd_ready;
  logic [DW-1:0]   rd_data;

  logic            done;
  logic            err;

  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i;
  logic [DW-1:0]   wb_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    input  wb_ack_i, wb_dat_i,
    output cmd_ready, wr_ready, rd_valid, rd_data, done, err,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    output wb_ack_i, wb_dat_i,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done, err,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// Command-driven Wishbone B4 burst master: one (we, addr, len) command becomes one CYC of
// len+1 incrementing beats, fed/drained by valid-ready streams, with a per-beat ack timeout.
module wb_burst_master #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int LENW = 8,
  parameter int TMO  = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_resetn,
  wb_burst_master_if.master  bus
);

  localparam int            SW         = DW / 8;
  localparam logic [AW-1:0] STEP       = AW'(SW);
  localparam logic [AW-1:0] ALIGN_MASK = ~(AW'(SW - 1));
  localparam logic [15:0]   TMO_LAST   = 16'(TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LENW-1:0] beats_q, beats_d;
  logic            single_q, single_d;
  logic            loaded_q, loaded_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic            rd_valid_q, rd_valid_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic [15:0]     tmo_q, tmo_d;
  logic            cyc_q, cyc_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            stb;
  logic            ack;
  logic            last;
  logic            tmo_hit;
  logic            wr_rdy;
  logic            wr_take;
  logic            cyc;
  logic [2:0]      cti;

  // Address arithmetic wraps silently at 2**AW.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return a + STEP;
  endfunction

  function automatic logic [2:0] beat_cti(input logic single, input logic is_last);
    if (single)       return 3'b000;
    else if (is_last) return 3'b111;
    else              return 3'b010;
  endfunction

  always_comb begin
    stb = 1'b0;
    case (state_q)
      S_WRITE: stb = loaded_q;
      S_READ:  stb = !rd_valid_q || bus.rd_ready;
      default: stb = 1'b0;
    endcase
  end

  // Acks while stb is low never count; the final ack must not pull in a beat of the next burst.
  assign ack     = stb && bus.wb_ack_i;
  assign last    = (beats_q == '0);
  assign tmo_hit = stb && !bus.wb_ack_i && (tmo_q == TMO_LAST);
  assign wr_rdy  = (state_q == S_WRITE) && (!loaded_q || (ack && !last));
  assign wr_take = wr_rdy && bus.wr_valid;
  assign cyc     = cyc_q || stb;
  assign cti     = beat_cti(single_q, last);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    single_d   = single_q;
    loaded_d   = loaded_q;
    wdat_d     = wdat_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    tmo_d      = (stb && !ack) ? tmo_q + 16'd1 : 16'd0;
    cyc_d      = cyc_q || stb;
    done_d     = 1'b0;
    err_d      = 1'b0;

    // A held read beat drains even after the burst has ended or aborted.
    if (bus.rd_ready) begin
      rd_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d   = bus.cmd_addr & ALIGN_MASK;
          beats_d  = bus.cmd_len;
          single_d = (bus.cmd_len == '0);
          loaded_d = 1'b0;
          cyc_d    = 1'b0;
          tmo_d    = 16'd0;
          state_d  = bus.cmd_we ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (wr_take) begin
          loaded_d = 1'b1;
          wdat_d   = bus.wr_data;
        end else if (ack) begin
          loaded_d = 1'b0;
        end
      end
      S_READ: begin
        if (ack) begin
          rd_data_d  = bus.wb_dat_i;
          rd_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) begin
      if (ack) begin
        addr_d  = next_addr(addr_q);
        beats_d = beats_q - LENW'(1);
        if (last) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          cyc_d    = 1'b0;
          loaded_d = 1'b0;
          tmo_d    = 16'd0;
        end
      end else if (tmo_hit) begin
        // Abort: the loaded write beat is dropped, unsent beats stay upstream.
        state_d  = S_IDLE;
        err_d    = 1'b1;
        cyc_d    = 1'b0;
        loaded_d = 1'b0;
        tmo_d    = 16'd0;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      beats_q    <= '0;
      single_q   <= 1'b0;
      loaded_q   <= 1'b0;
      wdat_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      tmo_q      <= 16'd0;
      cyc_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      single_q   <= single_d;
      loaded_q   <= loaded_d;
      wdat_q     <= wdat_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      tmo_q      <= tmo_d;
      cyc_q      <= cyc_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.wr_ready  = wr_rdy;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.wb_cyc_o  = cyc;
  assign bus.wb_stb_o  = stb;
  assign bus.wb_we_o   = (state_q == S_WRITE);
  assign bus.wb_addr_o = addr_q;
  assign bus.wb_dat_o  = wdat_q;
  assign bus.wb_sel_o  = cyc ? {SW{1'b1}} : {SW{1'b0}};
  assign bus.wb_cti_o  = cyc ? cti : 3'b000;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: a streaming driver plus an auto-acking Wishbone slave
// whose read data is 0xA5000000|addr (0xDEADBEEF at 0x40).
module tb_wb_burst_master;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic ack_en = 1'b1;

  int checks   = 0;
  int failures = 0;

  wb_burst_master_if #(.AW(32), .DW(32), .LENW(8)) bus ();

  wb_burst_master #(.AW(32), .DW(32), .LENW(8), .TMO(8)) dut (
    .wb_clk_i  (clk),
    .wb_resetn (rstn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  assign bus.wb_ack_i = bus.wb_stb_o & ack_en;
  assign bus.wb_dat_i = (bus.wb_addr_o == 32'h40) ? 32'hDEADBEEF : (32'hA500_0000 | bus.wb_addr_o);

  logic [31:0] ack_addr[$];
  logic [2:0]  ack_cti[$];
  logic [31:0] ack_wdat[$];
  logic [31:0] rd_got[$];
  int done_cnt, err_cnt, done_c, err_c, first_stb, last_ack_c;
  int stall_cyc, cyc_broke, busy_rdy;
  logic cyc_at_end, rdy_at_end;

  task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [7:0] len,
                         input logic [31:0] wr_base, input int wr_gap, input int stall_at,
                         input int stall_len, input logic ack_on, input int max_cyc);
    int gap, widx, stall_left, tail;
    logic take, cyc_seen;
    ack_addr.delete(); ack_cti.delete(); ack_wdat.delete(); rd_got.delete();
    done_cnt = 0; err_cnt = 0; done_c = -1; err_c = -1; first_stb = -1; last_ack_c = -1;
    stall_cyc = 0; cyc_broke = 0; busy_rdy = 0; cyc_at_end = 1'b1; rdy_at_end = 1'b0;
    gap = 0; widx = 0; stall_left = stall_len; tail = -1; cyc_seen = 1'b0;
    ack_en = ack_on;
    for (int c = 0; c < max_cyc; c++) begin
      bus.cmd_valid = (c == 0);
      bus.cmd_we    = we;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      bus.wr_valid  = we && (gap == 0) && (widx <= int'(len));
      bus.wr_data   = wr_base + 32'(widx);
      if (stall_left > 0 && rd_got.size() >= stall_at) begin
        bus.rd_ready = 1'b0;
        stall_left--;
      end else begin
        bus.rd_ready = 1'b1;
      end
      #1;
      if (bus.done) begin
        done_cnt++;
        if (done_c < 0) begin done_c = c; cyc_at_end = bus.wb_cyc_o; rdy_at_end = bus.cmd_ready; end
      end
      if (bus.err) begin
        err_cnt++;
        if (err_c < 0) begin err_c = c; cyc_at_end = bus.wb_cyc_o; rdy_at_end = bus.cmd_ready; end
      end
      if (bus.wb_stb_o && first_stb < 0) first_stb = c;
      if (bus.wb_stb_o && bus.wb_ack_i) begin
        ack_addr.push_back(bus.wb_addr_o);
        ack_cti.push_back(bus.wb_cti_o);
        ack_wdat.push_back(bus.wb_dat_o);
        last_ack_c = c;
      end
      if (bus.rd_valid && bus.rd_ready) rd_got.push_back(bus.rd_data);
      take = bus.wr_valid && bus.wr_ready;
      if (bus.wb_cyc_o) cyc_seen = 1'b1;
      else if (cyc_seen && done_c < 0 && err_c < 0) cyc_broke++;
      if (bus.wb_cyc_o && !bus.wb_stb_o) stall_cyc++;
      if (bus.cmd_ready && bus.wb_cyc_o) busy_rdy++;
      @(posedge clk); #1;
      if (take) begin widx++; gap = wr_gap; end
      else if (gap > 0) gap--;
      if ((done_c >= 0 || err_c >= 0) && tail < 0) tail = 2;
      else if (tail > 0) tail--;
      if (tail == 0) break;
    end
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b1;
    ack_en        = 1'b1;
  endtask

  task automatic test_reset();
    logic [110:0] outs;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs = {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_addr_o, bus.wb_dat_o, bus.wb_sel_o,
            bus.wb_cti_o, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.done, bus.err, 1'b0};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%0h exp=0", outs); end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_burst();
    run_cmd(1'b1, 32'h100, 8'd3, 32'h0, 0, 0, 0, 1'b1, 40);
    checks++;
    if (ack_addr.size() !== 4) begin failures++; $display("FAIL wr_beats got=%0d exp=4", ack_addr.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ack_addr[i] !== 32'h100 + 32'(4*i)) begin failures++; $display("FAIL wr_addr[%0d] got=%h exp=%h", i, ack_addr[i], 32'h100 + 32'(4*i)); end
        checks++;
        if (ack_cti[i] !== ((i == 3) ? 3'b111 : 3'b010)) begin failures++; $display("FAIL wr_cti[%0d] got=%b", i, ack_cti[i]); end
        checks++;
        if (ack_wdat[i] !== 32'(i)) begin failures++; $display("FAIL wr_dat[%0d] got=%h exp=%h", i, ack_wdat[i], i); end
      end
    end
    checks++;
    if (first_stb !== 2) begin failures++; $display("FAIL wr_first_stb got=%0d exp=2", first_stb); end
    checks++;
    if (done_cnt !== 1 || err_cnt !== 0) begin failures++; $display("FAIL wr_done got=%0d/%0d exp=1/0", done_cnt, err_cnt); end
    checks++;
    if (done_c - last_ack_c !== 1) begin failures++; $display("FAIL wr_done_lat got=%0d exp=1", done_c - last_ack_c); end
    checks++;
    if (cyc_at_end !== 1'b0 || rdy_at_end !== 1'b1) begin failures++; $display("FAIL wr_end cyc=%b rdy=%b exp 0/1", cyc_at_end, rdy_at_end); end
    checks++;
    if (cyc_broke !== 0 || busy_rdy !== 0) begin failures++; $display("FAIL wr_cyc broke=%0d busyrdy=%0d exp 0/0", cyc_broke, busy_rdy); end
  endtask

  task automatic test_read_single();
    run_cmd(1'b0, 32'h40, 8'd0, 32'h0, 0, 0, 0, 1'b1, 40);
    checks++;
    if (ack_cti.size() !== 1) begin failures++; $display("FAIL rd1_beats got=%0d exp=1", ack_cti.size()); end
    else begin
      checks++;
      if (ack_cti[0] !== 3'b000) begin failures++; $display("FAIL rd1_cti got=%b exp=000", ack_cti[0]); end
    end
    checks++;
    if (rd_got.size() !== 1) begin failures++; $display("FAIL rd1_count got=%0d exp=1", rd_got.size()); end
    else begin
      checks++;
      if (rd_got[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL rd1_data got=%h exp=deadbeef", rd_got[0]); end
    end
    checks++;
    if (first_stb !== 1) begin failures++; $display("FAIL rd1_first_stb got=%0d exp=1", first_stb); end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL rd1_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_read_stall();
    run_cmd(1'b0, 32'h200, 8'd7, 32'h0, 0, 2, 5, 1'b1, 60);
    checks++;
    if (rd_got.size() !== 8) begin failures++; $display("FAIL rds_count got=%0d exp=8", rd_got.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rd_got[i] !== 32'hA500_0200 + 32'(4*i)) begin failures++; $display("FAIL rds_data[%0d] got=%h exp=%h", i, rd_got[i], 32'hA500_0200 + 32'(4*i)); end
      end
    end
    checks++;
    if (stall_cyc !== 5) begin failures++; $display("FAIL rds_stall got=%0d exp=5", stall_cyc); end
    checks++;
    if (cyc_broke !== 0) begin failures++; $display("FAIL rds_cyc_broke got=%0d exp=0", cyc_broke); end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL rds_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_write_gaps();
    run_cmd(1'b1, 32'h200, 8'd3, 32'h1111_0000, 2, 0, 0, 1'b1, 60);
    checks++;
    if (ack_addr.size() !== 4) begin failures++; $display("FAIL wg_beats got=%0d exp=4", ack_addr.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ack_addr[i] !== 32'h200 + 32'(4*i) || ack_wdat[i] !== 32'h1111_0000 + 32'(i)) begin
          failures++;
          $display("FAIL wg_beat[%0d] got=%h/%h exp=%h/%h", i, ack_addr[i], ack_wdat[i], 32'h200 + 32'(4*i), 32'h1111_0000 + 32'(i));
        end
      end
    end
    checks++;
    if (stall_cyc !== 6) begin failures++; $display("FAIL wg_stall got=%0d exp=6", stall_cyc); end
    checks++;
    if (cyc_broke !== 0 || done_cnt !== 1) begin failures++; $display("FAIL wg_cyc broke=%0d done=%0d exp 0/1", cyc_broke, done_cnt); end
  endtask

  task automatic test_timeout();
    run_cmd(1'b0, 32'h500, 8'd3, 32'h0, 0, 0, 0, 1'b0, 40);
    checks++;
    if (err_cnt !== 1 || done_cnt !== 0) begin failures++; $display("FAIL tmo_pulse err=%0d done=%0d exp 1/0", err_cnt, done_cnt); end
    checks++;
    if (err_c - first_stb !== 8) begin failures++; $display("FAIL tmo_lat got=%0d exp=8", err_c - first_stb); end
    checks++;
    if (cyc_at_end !== 1'b0 || rdy_at_end !== 1'b1) begin failures++; $display("FAIL tmo_end cyc=%b rdy=%b exp 0/1", cyc_at_end, rdy_at_end); end
    checks++;
    if (rd_got.size() !== 0) begin failures++; $display("FAIL tmo_rd got=%0d exp=0", rd_got.size()); end
  endtask

  task automatic test_addr_wrap();
    run_cmd(1'b1, 32'hFFFF_FFFE, 8'd1, 32'hCAFE_0000, 0, 0, 0, 1'b1, 40);
    checks++;
    if (ack_addr.size() !== 2) begin failures++; $display("FAIL wrap_beats got=%0d exp=2", ack_addr.size()); end
    else begin
      checks++;
      if (ack_addr[0] !== 32'hFFFF_FFFC || ack_addr[1] !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h,%h exp=fffffffc,0", ack_addr[0], ack_addr[1]); end
      checks++;
      if (ack_cti[0] !== 3'b010 || ack_cti[1] !== 3'b111) begin failures++; $display("FAIL wrap_cti got=%b,%b exp=010,111", ack_cti[0], ack_cti[1]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [110:0] outs;
    int acks;
    bit hit;
    acks = 0; hit = 1'b0;
    ack_en = 1'b1;
    for (int c = 0; c < 20 && !hit; c++) begin
      bus.cmd_valid = (c == 0);
      bus.cmd_we    = 1'b1;
      bus.cmd_addr  = 32'h300;
      bus.cmd_len   = 8'd7;
      bus.wr_valid  = 1'b1;
      bus.wr_data   = 32'h7700_0000 + 32'(c);
      bus.rd_ready  = 1'b1;
      #1;
      if (bus.wb_stb_o && bus.wb_ack_i) acks++;
      if (acks == 2) begin rstn = 1'b0; hit = 1'b1; end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b0;
    checks++;
    if (!hit) begin failures++; $display("FAIL rstmid_reach got=%0d acks exp=2", acks); end
    outs = {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_addr_o, bus.wb_dat_o, bus.wb_sel_o,
            bus.wb_cti_o, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.done, bus.err, 1'b0};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL rstmid_outputs got=%0h exp=0", outs); end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid_cmd_ready got=%b exp=1", bus.cmd_ready); end
    rstn = 1'b1;
    @(posedge clk); #1;
    run_cmd(1'b1, 32'h400, 8'd1, 32'h55, 0, 0, 0, 1'b1, 40);
    checks++;
    if (ack_addr.size() !== 2) begin failures++; $display("FAIL rstmid_beats got=%0d exp=2", ack_addr.size()); end
    else begin
      checks++;
      if (ack_addr[0] !== 32'h400 || ack_addr[1] !== 32'h404 || ack_wdat[0] !== 32'h55 || ack_wdat[1] !== 32'h56) begin
        failures++;
        $display("FAIL rstmid_burst got=%h:%h %h:%h exp=400:55 404:56", ack_addr[0], ack_wdat[0], ack_addr[1], ack_wdat[1]);
      end
    end
    checks++;
    if (done_cnt !== 1 || err_cnt !== 0 || first_stb !== 2) begin
      failures++;
      $display("FAIL rstmid_done done=%0d err=%0d stb@%0d exp 1/0/2", done_cnt, err_cnt, first_stb);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b1;
    #1;
    test_reset();
    test_write_burst();
    test_read_single();
    test_read_stall();
    test_write_gaps();
    test_timeout();
    test_addr_wrap();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
